divider_core: RTL and testbench
===============================

// Module: divider_core
//
// PURPOSE
//   Sequential unsigned integer divider: quotient = numerator / denominator and
//   remainder = numerator % denominator, computed by restoring division at one
//   quotient bit per clock. A level-sensitive control_i start/release handshake
//   drives it, and status_o reports busy, divide-by-zero and done. Used as a
//   leaf arithmetic unit in a single clock domain.
//
// PARAMETERS
//   WIDTH  8  operand and result width in bits; iteration count = WIDTH
//
// PORTS
//   calculation_clk  in   1      sole clock, rising edge
//   rst_n            in   1      asynchronous reset, active low
//   denominator_i    in   WIDTH  divisor, sampled at start
//   numerator_i      in   WIDTH  dividend, sampled at start
//   remainder_o      out  WIDTH  registered remainder
//   quotient_o       out  WIDTH  registered quotient
//   control_i        in   1      start request (level); release by driving low
//   status_o         out  3      [0] busy, [1] div_by_zero, [2] done
//
// BEHAVIOUR
//   - Interface: one clock (calculation_clk); reset rst_n is asynchronous, active low.
//   - Reset: state=IDLE; quotient_o, remainder_o, status_o = 0; internal regs = 0.
//   - FSM states: IDLE, CALC, DONE.
//   - IDLE: on an edge with control_i=1, latch both operands and clear status_o[2:1].
//       denominator != 0 -> CALC: busy=1, iteration counter = WIDTH.
//       denominator == 0 -> DONE directly: status_o[1]=1, status_o[2]=1, busy never
//       asserted; results set per CONFIGURATION.
//   - CALC: each cycle, shift the partial remainder left and bring in the next
//     numerator MSB. If partial >= denominator, subtract and set the quotient bit to 1;
//     otherwise set it to 0. Use a WIDTH+1-bit partial remainder so no overflow occurs.
//   - CALC timing: busy is high for exactly WIDTH cycles. On the edge after the last
//     iteration: state=DONE, quotient_o/remainder_o update, busy=0, status_o[2]=1.
//   - Latency (start-sampling edge to done visible): WIDTH+1 edges.
//   - control_i changes during CALC are ignored; the computation always completes.
//   - DONE: results and status_o[2:1] hold. The FSM returns to IDLE only when
//     control_i=0, so a held-high control_i never retriggers. In IDLE, outputs hold
//     their last values until the next start.
//   - Operand inputs are ignored except on the start edge.
//   - status_o[0] = (state==CALC), registered.
//   - Asserting rst_n mid-operation aborts immediately; all outputs go to 0.
//   - Unsigned arithmetic only. Quotient and remainder are always exact:
//     numerator = quotient*denominator + remainder, with remainder < denominator.
//
// CONFIGURATION
//   DIVIDER_DIV0_SATURATE_EN
//     defined:   on divide-by-zero, quotient_o = all ones and remainder_o = numerator.
//     undefined: on divide-by-zero, quotient_o = 0 and remainder_o = 0.
//   The status_o flags are identical in both builds.
//
// TESTING
//   - 200/7: start, wait busy=1, drop control_i, wait busy=0 -> quotient 0x1C,
//     remainder 0x04, status 3'b100.
//   - 255/1 -> quotient 0xFF, remainder 0x00. 128/127 -> quotient 0x01, remainder
//     0x01. 5/9 -> quotient 0x00, remainder 0x05.
//   - 100/0 with control_i=1 -> status_o[1]=1 and status_o[2]=1 one edge later,
//     busy stays 0; quotient/remainder = 0 (0xFF/0x64 with DIVIDER_DIV0_SATURATE_EN).
//   - Hold control_i=1 through done -> no second busy pulse. Drop control_i, then
//     raise it -> new division starts.
//   - Busy-width check: busy high for exactly 8 cycles; done is first visible 9 edges
//     after the start edge.
//   - Assert rst_n low in the middle of CALC -> outputs all 0 immediately. Release,
//     then 10 random numerator in [128,255] / denominator in [1,127] -> all match the
//     reference model.

Source files
------------

// File: rtl/divider_core.sv
// divider_core: sequential unsigned restoring divider, one quotient bit per clock.
// Optional build macro DIVIDER_DIV0_SATURATE_EN: on divide-by-zero return
// quotient = all ones and remainder = numerator instead of zeros.
module divider_core #(
  parameter int WIDTH = 8
) (
  input  logic             calculation_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] denominator_i,
  input  logic [WIDTH-1:0] numerator_i,
  output logic [WIDTH-1:0] remainder_o,
  output logic [WIDTH-1:0] quotient_o,
  input  logic             control_i,
  output logic [2:0]       status_o
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] partial_q, partial_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_d, remainder_d;
  logic             busy_d, dz_d, done_d;
  logic [WIDTH:0]   shifted, diff;
  logic             ge, last, den_zero;
  assign den_zero = denominator_i == '0;
  assign last     = cnt_q == CW'(1);
  // The dividend register doubles as the quotient: numerator bits shift out
  // of the top while quotient bits shift in at the bottom. Partial remainder
  // is extended to WIDTH+1 bits by the shift; the borrow of the trial
  // subtraction tells whether the quotient bit is 1.
  assign shifted  = {partial_q, dividend_q[WIDTH-1]};
  assign diff     = shifted - {1'b0, den_q};
  assign ge       = ~diff[WIDTH];
  // State register with asynchronous abort.
  always_ff @(posedge calculation_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // Next state: start from IDLE, count through CALC, leave DONE only on release.
  always_comb begin
    state_d = (state_q == IDLE) ? (control_i ? (den_zero ? DONE : CALC) : IDLE) :
              (state_q == CALC) ? (last ? DONE : CALC) :
              (control_i ? DONE : IDLE);
  end
  // Datapath and output next-values; everything holds unless started or iterating.
  always_comb begin
    partial_d   = partial_q;
    dividend_d  = dividend_q;
    den_d       = den_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_o;
    remainder_d = remainder_o;
    dz_d        = status_o[1];
    done_d      = status_o[2];
    if (state_q == IDLE && control_i) begin
      partial_d  = '0;
      dividend_d = numerator_i;
      den_d      = denominator_i;
      cnt_d      = CW'(WIDTH);
      dz_d       = den_zero;
      done_d     = den_zero;
      if (den_zero) begin
`ifdef DIVIDER_DIV0_SATURATE_EN
        quotient_d  = '1;
        remainder_d = numerator_i;
`else
        quotient_d  = '0;
        remainder_d = '0;
`endif
      end
    end else if (state_q == CALC) begin
      partial_d  = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      dividend_d = {dividend_q[WIDTH-2:0], ge};
      cnt_d      = cnt_q - CW'(1);
      if (last) begin
        quotient_d  = dividend_d;
        remainder_d = partial_d;
        done_d      = 1'b1;
      end
    end
    busy_d = state_d == CALC;
  end
  // Datapath and registered outputs.
  always_ff @(posedge calculation_clk or negedge rst_n) begin
    if (!rst_n) begin
      partial_q   <= '0;
      dividend_q  <= '0;
      den_q       <= '0;
      cnt_q       <= '0;
      quotient_o  <= '0;
      remainder_o <= '0;
      status_o    <= '0;
    end else begin
      partial_q   <= partial_d;
      dividend_q  <= dividend_d;
      den_q       <= den_d;
      cnt_q       <= cnt_d;
      quotient_o  <= quotient_d;
      remainder_o <= remainder_d;
      status_o    <= {done_d, dz_d, busy_d};
    end
  end
endmodule

// File: tb/tb_divider_core.sv
// tb_divider_core: directed and randomized self-checking bench for divider_core.
module tb_divider_core;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       control = 1'b0;
  logic [7:0] num = '0, den = '0;
  logic [7:0] q, r;
  logic [2:0] st;
  int checks = 0, fails = 0;

  divider_core #(.WIDTH(8)) dut (
    .calculation_clk(clk),
    .rst_n(rst_n),
    .denominator_i(den),
    .numerator_i(num),
    .remainder_o(r),
    .quotient_o(q),
    .control_i(control),
    .status_o(st)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start a division, release control, wait for done, then return to IDLE.
  task automatic run_div(input logic [7:0] n, input logic [7:0] d, output bit timed_out);
    num = n; den = d; control = 1'b1;
    tick();
    control = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (st[2]) begin timed_out = 1'b0; break; end
      tick();
    end
    tick();
  endtask

  task automatic test_reset;
    #1;
    checks++; if (q !== 8'h00) begin fails++; $display("FAIL reset_q got %h want 00", q); end
    checks++; if (r !== 8'h00) begin fails++; $display("FAIL reset_r got %h want 00", r); end
    checks++; if (st !== 3'b000) begin fails++; $display("FAIL reset_status got %b want 000", st); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    bit seen;
    num = 8'd200; den = 8'd7; control = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin tick(); seen = st[0]; end
    checks++; if (!seen) begin fails++; $display("FAIL basic_busy_rise got %b want 1", seen); end
    control = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = !st[0]; end
    checks++; if (!seen) begin fails++; $display("FAIL basic_busy_fall got %b want 1", seen); end
    checks++; if (q !== 8'h1C) begin fails++; $display("FAIL basic_q got %h want 1c", q); end
    checks++; if (r !== 8'h04) begin fails++; $display("FAIL basic_r got %h want 04", r); end
    checks++; if (st !== 3'b100) begin fails++; $display("FAIL basic_status got %b want 100", st); end
    tick();
  endtask

  task automatic test_directed;
    logic [7:0] vn [3] = '{8'd255, 8'd128, 8'd5};
    logic [7:0] vd [3] = '{8'd1, 8'd127, 8'd9};
    logic [7:0] vq [3] = '{8'hFF, 8'h01, 8'h00};
    logic [7:0] vr [3] = '{8'h00, 8'h01, 8'h05};
    bit to;
    for (int i = 0; i < 3; i++) begin
      run_div(vn[i], vd[i], to);
      checks++; if (to) begin fails++; $display("FAIL dir%0d_timeout got 1 want 0", i); end
      checks++; if (q !== vq[i]) begin fails++; $display("FAIL dir%0d_q got %h want %h", i, q, vq[i]); end
      checks++; if (r !== vr[i]) begin fails++; $display("FAIL dir%0d_r got %h want %h", i, r, vr[i]); end
    end
  endtask

  task automatic test_div_zero;
    logic [7:0] eq, er;
`ifdef DIVIDER_DIV0_SATURATE_EN
    eq = 8'hFF; er = 8'h64;
`else
    eq = 8'h00; er = 8'h00;
`endif
    num = 8'd100; den = 8'd0; control = 1'b1;
    tick();
    checks++; if (st !== 3'b110) begin fails++; $display("FAIL div0_status got %b want 110", st); end
    checks++; if (q !== eq) begin fails++; $display("FAIL div0_q got %h want %h", q, eq); end
    checks++; if (r !== er) begin fails++; $display("FAIL div0_r got %h want %h", r, er); end
    tick(); tick(); tick();
    checks++; if (st !== 3'b110) begin fails++; $display("FAIL div0_hold got %b want 110", st); end
    control = 1'b0;
    tick();
  endtask

  // Control held high through done: one busy pulse of 8 cycles, done on the
  // 9th edge counting the start edge as the first; release then restart.
  task automatic test_timing_hold;
    int busy_cnt = 0, first_done = 0;
    num = 8'd200; den = 8'd7; control = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (st[0]) busy_cnt++;
      if (st[2] && first_done == 0) first_done = i;
    end
    checks++; if (busy_cnt != 8) begin fails++; $display("FAIL busy_width got %0d want 8", busy_cnt); end
    checks++; if (first_done != 9) begin fails++; $display("FAIL done_latency got %0d want 9", first_done); end
    checks++; if (q !== 8'h1C) begin fails++; $display("FAIL hold_q got %h want 1c", q); end
    control = 1'b0;
    tick();
    checks++; if (st !== 3'b100) begin fails++; $display("FAIL idle_hold_status got %b want 100", st); end
    num = 8'd5; den = 8'd9; control = 1'b1;
    tick();
    checks++; if (st !== 3'b001) begin fails++; $display("FAIL restart_status got %b want 001", st); end
    control = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (q !== 8'h00 || r !== 8'h05) begin fails++; $display("FAIL restart_result got %h/%h want 00/05", q, r); end
  endtask

  task automatic test_reset_mid;
    num = 8'd200; den = 8'd7; control = 1'b1;
    tick();
    control = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (q !== 8'h00 || r !== 8'h00 || st !== 3'b000) begin
      fails++; $display("FAIL reset_mid got q=%h r=%h st=%b want 00 00 000", q, r, st);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (st !== 3'b000) begin fails++; $display("FAIL reset_mid_idle got %b want 000", st); end
  endtask

  task automatic test_random;
    logic [7:0] n, d;
    bit to;
    for (int i = 0; i < 10; i++) begin
      n = 8'($urandom_range(255, 128));
      d = 8'($urandom_range(127, 1));
      run_div(n, d, to);
      checks++; if (to || q !== n / d || r !== n % d) begin
        fails++; $display("FAIL rand%0d %0d/%0d got q=%0d r=%0d want q=%0d r=%0d", i, n, d, q, r, n / d, n % d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_div_zero();
    test_timing_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
